ahb2apb_bridge: RTL
===================

Name: ahb2apb_bridge

Overview:
- AHB-Lite responder on the system AHB bus (E902 `biu_pad_*` side) and APB initiator toward the peripheral slaves inside the system peripheral subsystem.
- Converts each single AHB transfer into one APB SETUP/ACCESS sequence.
- Decodes the APB slave select from address bits and returns read data, wait states and errors to the CPU.
- Handles only single transfers; HBURST is ignored, matching E902 behaviour.

Parameters:
- SLV_IDX_LSB, 12: lowest haddr bit of the slave index (4 KB per slave).
- SLV_IDX_W, 4: slave index width. NUM_SLV = 2**SLV_IDX_W.
- PADDR_W, 12: width of paddr, taken from haddr[PADDR_W-1:0].

Ports:
- sys_clk  in  1  bus clock.
- sys_reset  in  1  asynchronous, active-high reset.
- hsel  in  1  bridge selected.
- haddr  in  32  AHB address.
- htrans  in  2  AHB transfer type.
- hwrite  in  1  AHB write.
- hsize  in  3  AHB size.
- hprot  in  4  AHB protection.
- hwdata  in  32  AHB write data, valid in the data phase.
- hready_in  in  1  bus-level HREADY.
- hready  out  1  bridge HREADY.
- hresp  out  1  0 = OKAY, 1 = ERROR.
- hrdata  out  32  read data.
- paddr  out  PADDR_W  APB address.
- psel  out  NUM_SLV  one-hot APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB write.
- pwdata  out  32  APB write data.
- prdata  in  32*NUM_SLV  flattened slave read data; slave i at [32*i +: 32].
- pready  in  NUM_SLV  per-slave ready.
- pslverr  in  NUM_SLV  per-slave error.
- pstrb  out  4  APB4 only.
- pprot  out  3  APB4 only.

Behaviour:
- Reset (async, sys_reset=1): state IDLE. hready=1, hresp=0, hrdata=0, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, pstrb=0, pprot=0. Assertion mid-transfer aborts immediately with the same values; no APB completion is owed.
- Accept condition: hsel & htrans[1] & hready_in & hready. On accept, register haddr, hwrite, hsize, hprot and the slave index idx = haddr[SLV_IDX_LSB +: SLV_IDX_W].
- htrans IDLE/BUSY, or hsel=0: zero-wait OKAY response, no APB activity.
- Illegal transfer: hsize > 2, halfword with haddr[0]=1, or word with haddr[1:0]!=0.
  - No APB access is made.
  - Next cycle: ERR1 (hready=0, hresp=1).
  - Then: ERR2 (hready=1, hresp=1).
  - Then return to IDLE.
- States and outputs:
  - IDLE: hready=1, hresp=0. Accept → SETUP (or ERR1 if illegal).
  - SETUP: psel[idx]=1, penable=0, hready=0. pwdata is latched from hwdata this cycle; hwdata is valid in the data phase. Always → ACCESS next cycle.
  - ACCESS: psel[idx]=1, penable=1.
    - pready[idx]=0: hready=0; stay.
    - pready[idx]=1 & pslverr[idx]=0: hready=1, hresp=0, hrdata=prdata[idx] (combinational, valid this cycle only). Then either accept the next transfer (→ SETUP/ERR1, psel held/re-decoded, penable drops) or → IDLE.
    - pready[idx]=1 & pslverr[idx]=1: hready=0, hresp=1 → ERR2.
  - ERR2: hready=1, hresp=1, psel=0. A new transfer may be accepted (→ SETUP/ERR1); otherwise → IDLE.
- Latency: zero-wait APB slave gives 1 AHB wait state, so the data phase is 2 cycles. Each extra pready-low cycle adds 1.
- hrdata is 0 outside the completing ACCESS cycle. pwdata, paddr and pwrite are stable from SETUP through the end of ACCESS.
- No new address is accepted while hready=0, so SETUP and the stalled part of ACCESS never overlap an acceptance.

Optional Feature:
- Macro: AHB2APB_APB4_EN.
- Defined:
  - pstrb is derived from registered hsize/haddr[1:0]: byte → 1<<a, half → 3<<a, word → 4'hF; 0 on reads.
  - pprot = {~hprot[0], 1'b0, hprot[1]}: instruction, secure, privileged.
- Undefined: pstrb and pprot ports are absent (APB3); slaves assume full-word writes.

Decomposition:
- Package ahb_apb_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ.
  - HSIZE_BYTE/HALF/WORD.
  - The state enum {IDLE, SETUP, ACCESS, ERR1, ERR2}.
  - HRESP_OKAY/ERROR.
- Sub-module ahb2apb_strb_gen: combinational legality check plus pstrb generation from hsize/haddr[1:0].

Test Plan:
- Write 0x1000_3004 = 0xDEADBEEF with slave 3 ready-immediately → psel=4'b1000 (bit 3), paddr=0x004, pwdata=0xDEADBEEF, penable in 3rd cycle, hready low exactly 1 cycle, hresp=0.
- Read 0x1000_1010, slave 1 holds pready=0 for 3 cycles then prdata=0x12345678 → hready low 4 cycles, hrdata=0x12345678 on the completing cycle.
- Slave 2 returns pslverr=1 on write → two-cycle ERROR: (hready=0, hresp=1) then (hready=1, hresp=1); next transfer accepted OKAY.
- Word write to 0x...0002 → ERR1/ERR2, no psel asserted. With AHB2APB_APB4_EN, byte write to offset 3 → pstrb=4'b1000.
- Back-to-back read slave 0 then write slave 5, second address phase in the completing cycle → SETUP for slave 5 immediately follows with no IDLE gap.
- Assert sys_reset during ACCESS → psel=0, penable=0, hready=1 combinationally; after release, an idle bus shows hready=1, hresp=0.

Source files
------------

// File: rtl/ahb_apb_pkg.sv
// Shared AHB/APB encodings and the bridge state type.
package ahb_apb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        ERR1,
        ERR2
    } state_e;

endpackage

// File: rtl/ahb2apb_strb_gen.sv
// Address-phase legality check (size/alignment) and APB4 byte-strobe generation.
module ahb2apb_strb_gen
    import ahb_apb_pkg::*;
(
    input  logic [2:0] hsize_i,
    input  logic [1:0] addr_lo_i,
    input  logic       write_i,
    output logic       legal_o,
    output logic [3:0] pstrb_o
);

    always_comb begin
        legal_o = 1'b1;
        pstrb_o = 4'h0;
        case (hsize_i)
            HSIZE_BYTE: pstrb_o = 4'b0001 << addr_lo_i;
            HSIZE_HALF: begin
                legal_o = ~addr_lo_i[0];
                pstrb_o = 4'b0011 << addr_lo_i;
            end
            HSIZE_WORD: begin
                legal_o = (addr_lo_i == 2'b00);
                pstrb_o = 4'hF;
            end
            default: legal_o = 1'b0;
        endcase
        // Reads and rejected transfers never carry strobes.
        if (!write_i || !legal_o) begin
            pstrb_o = 4'h0;
        end
    end

endmodule

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite single-transfer responder driving an APB initiator (one SETUP/ACCESS per transfer).
// Define AHB2APB_APB4_EN to add the APB4 pstrb/pprot ports.
module ahb2apb_bridge
    import ahb_apb_pkg::*;
#(
    parameter int  SLV_IDX_LSB = 12,
    parameter int  SLV_IDX_W   = 4,
    parameter int  PADDR_W     = 12,
    localparam int NUM_SLV     = 2 ** SLV_IDX_W
) (
    input  logic                    sys_clk,
    input  logic                    sys_reset,
    input  logic                    hsel,
    input  logic [31:0]             haddr,
    input  logic [1:0]              htrans,
    input  logic                    hwrite,
    input  logic [2:0]              hsize,
    input  logic [3:0]              hprot,
    input  logic [31:0]             hwdata,
    input  logic                    hready_in,
    output logic                    hready,
    output logic                    hresp,
    output logic [31:0]             hrdata,
    output logic [PADDR_W-1:0]      paddr,
    output logic [NUM_SLV-1:0]      psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [31:0]             pwdata,
    input  logic [32*NUM_SLV-1:0]   prdata,
    input  logic [NUM_SLV-1:0]      pready,
    input  logic [NUM_SLV-1:0]      pslverr
`ifdef AHB2APB_APB4_EN
    ,
    output logic [3:0]              pstrb,
    output logic [2:0]              pprot
`endif
);

    state_e               state_q, state_d;
    logic [SLV_IDX_W-1:0] idx_q, idx_d;
    logic [PADDR_W-1:0]   paddr_q, paddr_d;
    logic                 pwrite_q, pwrite_d;
    logic [31:0]          pwdata_q, pwdata_d;
    logic [3:0]           strb_q, strb_d;
    logic [2:0]           prot_q, prot_d;
    logic                 legal;
    logic [3:0]           strb;
    logic                 accept;
    logic                 unused_bits;

    ahb2apb_strb_gen u_strb_gen (
        .hsize_i   (hsize),
        .addr_lo_i (haddr[1:0]),
        .write_i   (hwrite),
        .legal_o   (legal),
        .pstrb_o   (strb)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        strb_d   = strb_q;
        prot_d   = prot_q;
        hready   = 1'b1;
        hresp    = HRESP_OKAY;
        hrdata   = '0;
        psel     = '0;
        penable  = 1'b0;
        accept   = 1'b0;

        case (state_q)
            SETUP: begin
                hready      = 1'b0;
                psel[idx_q] = 1'b1;
                pwdata_d    = hwdata;
                state_d     = ACCESS;
            end
            ACCESS: begin
                psel[idx_q] = 1'b1;
                penable     = 1'b1;
                if (!pready[idx_q]) begin
                    hready = 1'b0;
                end else if (pslverr[idx_q]) begin
                    hready  = 1'b0;
                    hresp   = HRESP_ERROR;
                    state_d = ERR2;
                end else begin
                    hrdata  = prdata[32*idx_q +: 32];
                    state_d = IDLE;
                end
            end
            ERR1: begin
                hready  = 1'b0;
                hresp   = HRESP_ERROR;
                state_d = ERR2;
            end
            ERR2: begin
                hresp   = HRESP_ERROR;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Acceptance only happens while hready is high, so it never disturbs a live SETUP/stall.
        accept = hsel && htrans[1] && hready_in && hready;
        if (accept) begin
            state_d  = legal ? SETUP : ERR1;
            idx_d    = haddr[SLV_IDX_LSB +: SLV_IDX_W];
            paddr_d  = haddr[PADDR_W-1:0];
            pwrite_d = hwrite;
            strb_d   = strb;
            prot_d   = {~hprot[0], 1'b0, hprot[1]};
        end
    end

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            strb_q   <= '0;
            prot_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            strb_q   <= strb_d;
            prot_q   <= prot_d;
        end
    end

    // hwdata is only valid in the data phase, so SETUP forwards it live and ACCESS uses the latch.
    assign pwdata = (state_q == SETUP) ? hwdata : pwdata_q;
    assign paddr  = paddr_q;
    assign pwrite = pwrite_q;

`ifdef AHB2APB_APB4_EN
    assign pstrb       = strb_q;
    assign pprot       = prot_q;
    assign unused_bits = ^{haddr, htrans[0], hprot};
`else
    assign unused_bits = ^{haddr, htrans[0], hprot, strb_q, prot_q};
`endif

endmodule
